// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out stage feeding the
// serial sequence detector.
package piso_serializer_pkg;

    // Default word length, also used by the detector-side bench.
    localparam int SER_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer; master is the
// upstream word source, slave is the serializer itself.
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) ();

    logic             Load_valid;
    logic             Load_ready;
    logic [WIDTH-1:0] Data_in;
    logic             Dout;
    logic             Dout_valid;
    logic             Frame_done;

    modport master (
        output Load_valid,
        output Data_in,
        input  Load_ready,
        input  Dout,
        input  Dout_valid,
        input  Frame_done
    );

    modport slave (
        input  Load_valid,
        input  Data_in,
        output Load_ready,
        output Dout,
        output Dout_valid,
        output Frame_done
    );

endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per Clock, streaming words back to back.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    piso_serializer_if.slave    bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serializer: WIDTH must be at least 2");
    end

    state_e           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             last_bit;
    logic             accept;

    // The last-bit cycle doubles as a load slot so consecutive words abut.
    assign last_bit        = (state == ST_SHIFT) && (count == LAST);
    assign bus.Load_ready  = (state == ST_IDLE) || last_bit;
    assign accept          = bus.Load_valid && bus.Load_ready;

    // Outputs come from registered state only; idle line is held low.
    assign bus.Dout_valid  = (state == ST_SHIFT);
    assign bus.Frame_done  = last_bit;
    assign bus.Dout        = (state == ST_SHIFT) &&
                             (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        shreg_nxt = shreg;
        count_nxt = count;

        if (accept) begin
            state_nxt = ST_SHIFT;
            shreg_nxt = bus.Data_in;
            count_nxt = '0;
        end else if (state == ST_SHIFT) begin
            if (last_bit) begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end else begin
                shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (Reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            count <= count_nxt;
        end
    end

endmodule : piso_serializer
